xy_route_stepper: RTL and testbench
===================================

Name: xy_route_stepper

Overview:
- Parametrised hop-by-hop route generator for the 2-D mesh NoC.
- Accepts a packet header (source node, destination node) through a valid/ready handshake.
- Walks the path one hop per accepted output beat, emitting the current node and its one-hot output port.
- Supports XY or YX dimension order and arbitrary (non-power-of-two) mesh sizes, with range checking and hop counting.

Parameters:
- MESH_X, 4, number of columns (≥2)
- MESH_Y, 4, number of rows (≥2)
- XW, 2, bits of x coordinate; must satisfy 2^XW ≥ MESH_X
- YW, 2, bits of y coordinate; must satisfy 2^YW ≥ MESH_Y
- YX_FIRST, 0, 0 = XY order (resolve x first), 1 = YX order
- HCW, 4, hop counter width; must satisfy 2^HCW > MESH_X+MESH_Y-1

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  header valid
- in_ready  out  1  block can accept header
- in_src  in  XW+YW  source node, {x,y}, x in upper bits
- in_dest  in  XW+YW  destination node, {x,y}
- hop_valid  out  1  hop beat valid
- hop_ready  in  1  downstream accepts hop beat
- hop_node  out  XW+YW  node where this hop is taken, {x,y}
- hop_port  out  5  one-hot: [0] LOCAL, [1] EAST x+1, [2] WEST x-1, [3] NORTH y+1, [4] SOUTH y-1
- hop_count  out  HCW  index of current hop beat (0-based)
- route_done  out  1  one-cycle pulse after the LOCAL beat is accepted
- route_err  out  1  one-cycle pulse when a header is rejected as out of range

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - in_ready=1, hop_valid=0, hop_node=0, hop_port=0, hop_count=0, route_done=0, route_err=0.
  - Reset mid-route abandons the route; no done pulse is produced.
- FSM states: IDLE, STEP, plus a single-cycle FLAG used for done/err pulses.
- IDLE:
  - in_ready=1, hop_valid=0.
  - On in_valid&in_ready: latch dest and set cur=src, hop_count=0.
  - If any of src.x, dest.x ≥ MESH_X or src.y, dest.y ≥ MESH_Y: go to FLAG with route_err=1; no hop beats are emitted.
  - Otherwise go to STEP.
- STEP:
  - in_ready=0, hop_valid=1, hop_node=cur.
  - hop_port is a registered function of cur and dest.
  - XY order: x≠dest.x gives EAST/WEST by sign; else y≠dest.y gives NORTH/SOUTH; else LOCAL. YX order swaps the priority of the two dimensions.
  - While hop_valid & !hop_ready, hop_node/hop_port/hop_count hold stable.
  - On acceptance of a non-LOCAL beat: cur moves one step in the port direction, hop_count+1, and the next beat is valid the following cycle (one beat per cycle under continuous hop_ready).
  - On acceptance of the LOCAL beat: go to FLAG with route_done=1.
- FLAG:
  - One cycle with in_ready=0, hop_valid=0, and route_done or route_err high.
  - Returns to IDLE; pulses then clear.
- Latency and beat count:
  - Header accept at cycle N gives first hop_valid at N+1.
  - Total beats = |dx|+|dy|+1, the last always LOCAL.
  - src==dest yields exactly one LOCAL beat, hop_count=0.
- Arithmetic:
  - Coordinate steps never wrap (no torus); range checking guarantees cur stays inside the mesh.
  - hop_count never exceeds MESH_X+MESH_Y-2.
- Ignored inputs: in_valid is ignored outside IDLE, and the header is not latched.
- hop_port is always exactly one-hot while hop_valid=1.

Test Plan:
- 4x4, XY, src=0x0 (0,0), dest=0xB (2,3), hop_ready=1:
  - Beats: (0,0)E, (1,0)E, (2,0)N, (2,1)N, (2,2)N, (2,3)LOCAL, with hop_count 0..5.
  - route_done is pulsed the cycle after the last beat.
- Same header with YX_FIRST=1: beats are N,N,N,E,E,LOCAL, nodes (0,0),(0,1),(0,2),(0,3),(1,3),(2,3).
- src=dest=0x5: a single beat (1,1) LOCAL, hop_count=0, then route_done; in_ready returns 2 cycles after the beat is accepted.
- Backpressure: hold hop_ready=0 for 3 cycles mid-route. hop_node/hop_port/hop_count stay frozen, no beat is lost or duplicated, and the beat count is unchanged.
- MESH_X=3, MESH_Y=5, XW=2, YW=3, header dest={x=3,y=0}:
  - route_err is pulsed once, no hop_valid, and in_ready returns.
  - Then src=(2,4), dest=(0,0) routes W,W,S,S,S,S,LOCAL.
- Assert rst during the third beat of a route. Next cycle: hop_valid=0, in_ready=1, no route_done; a new header is then accepted normally.

Source files
------------

// File: rtl/xy_route_stepper.sv
// xy_route_stepper: hop-by-hop dimension-ordered route generator for a 2-D mesh.
// Accepts a {src,dest} header, range-checks it, then emits one beat per hop
// carrying the current node and its one-hot output port, ending with LOCAL.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        header handshake
//   in_src, in_dest          header nodes, {x,y} with x in the upper bits
//   hop_valid/hop_ready      hop beat handshake
//   hop_node, hop_port       node of this hop and one-hot port {S,N,W,E,LOCAL}
//   hop_count                0-based index of the current beat
//   route_done, route_err    one-cycle completion / rejection pulses
module xy_route_stepper #(
  parameter int unsigned MESH_X   = 4,
  parameter int unsigned MESH_Y   = 4,
  parameter int unsigned XW       = 2,
  parameter int unsigned YW       = 2,
  parameter int unsigned YX_FIRST = 0,
  parameter int unsigned HCW      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XW+YW-1:0] in_src,
  input  logic [XW+YW-1:0] in_dest,
  output logic             hop_valid,
  input  logic             hop_ready,
  output logic [XW+YW-1:0] hop_node,
  output logic [4:0]       hop_port,
  output logic [HCW-1:0]   hop_count,
  output logic             route_done,
  output logic             route_err
);

  localparam int unsigned NW = XW + YW;

  localparam logic [4:0] P_NONE  = 5'b00000;
  localparam logic [4:0] P_LOCAL = 5'b00001;
  localparam logic [4:0] P_EAST  = 5'b00010;
  localparam logic [4:0] P_WEST  = 5'b00100;
  localparam logic [4:0] P_NORTH = 5'b01000;
  localparam logic [4:0] P_SOUTH = 5'b10000;

  // One extra bit so a mesh size equal to 2^W still compares correctly
  localparam logic [XW:0] MX_L = (XW+1)'(MESH_X);
  localparam logic [YW:0] MY_L = (YW+1)'(MESH_Y);

  typedef enum logic [1:0] {IDLE, STEP, FLAG} state_e;

  state_e          state_q, state_d;
  logic [XW-1:0]   cx_q, cx_d, dx_q, dx_d;
  logic [YW-1:0]   cy_q, cy_d, dy_q, dy_d;
  logic [HCW-1:0]  cnt_q, cnt_d;
  logic [4:0]      port_q, port_d;
  logic            in_ready_q, hop_valid_q, done_q, done_d, err_q, err_d;

  logic [XW-1:0]   src_x, dst_x;
  logic [YW-1:0]   src_y, dst_y;
  logic            range_bad;

  assign src_x = in_src[NW-1:YW];
  assign src_y = in_src[YW-1:0];
  assign dst_x = in_dest[NW-1:YW];
  assign dst_y = in_dest[YW-1:0];

  assign range_bad = ({1'b0, src_x} >= MX_L) || ({1'b0, dst_x} >= MX_L) ||
                     ({1'b0, src_y} >= MY_L) || ({1'b0, dst_y} >= MY_L);

  // Port for the hop taken at (cx,cy) heading to (tx,ty) in the configured order
  function automatic logic [4:0] route_port(input logic [XW-1:0] cx,
                                            input logic [YW-1:0] cy,
                                            input logic [XW-1:0] tx,
                                            input logic [YW-1:0] ty);
    logic [4:0] px;
    logic [4:0] py;
    logic [4:0] res;
    px = P_NONE;
    py = P_NONE;
    if (cx < tx)      px = P_EAST;
    else if (cx > tx) px = P_WEST;
    if (cy < ty)      py = P_NORTH;
    else if (cy > ty) py = P_SOUTH;
    if (YX_FIRST != 0) res = (py != P_NONE) ? py : ((px != P_NONE) ? px : P_LOCAL);
    else               res = (px != P_NONE) ? px : ((py != P_NONE) ? py : P_LOCAL);
    return res;
  endfunction

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    port_d  = P_NONE;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          cx_d  = src_x;
          cy_d  = src_y;
          dx_d  = dst_x;
          dy_d  = dst_y;
          cnt_d = '0;
          if (range_bad) begin
            state_d = FLAG;
            err_d   = 1'b1;
          end else begin
            state_d = STEP;
          end
        end
      end
      STEP: begin
        if (hop_ready) begin
          if (port_q == P_LOCAL) begin
            state_d = FLAG;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + HCW'(1);
            // Range check on entry keeps every step inside the mesh
            unique case (1'b1)
              port_q[1]: cx_d = cx_q + XW'(1);
              port_q[2]: cx_d = cx_q - XW'(1);
              port_q[3]: cy_d = cy_q + YW'(1);
              port_q[4]: cy_d = cy_q - YW'(1);
              default:   ;
            endcase
          end
        end
      end
      FLAG:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == STEP) port_d = route_port(cx_d, cy_d, dx_d, dy_d);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cx_q        <= '0;
      cy_q        <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      cnt_q       <= '0;
      port_q      <= P_NONE;
      in_ready_q  <= 1'b1;
      hop_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      cnt_q       <= cnt_d;
      port_q      <= port_d;
      in_ready_q  <= (state_d == IDLE);
      hop_valid_q <= (state_d == STEP);
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign hop_valid  = hop_valid_q;
  assign hop_node   = {cx_q, cy_q};
  assign hop_port   = port_q;
  assign hop_count  = cnt_q;
  assign route_done = done_q;
  assign route_err  = err_q;

endmodule

// File: tb/tb_xy_route_stepper.sv
// Directed bench: three configurations (4x4 XY, 4x4 YX, 3x5 XY) driven from a
// table of hand-computed routes plus backpressure and mid-route reset sequences.
module tb_xy_route_stepper;

  logic       clk = 1'b0;
  logic       rst;
  logic       hop_ready;
  logic [2:0] vld;
  logic [4:0] src, dst;
  logic [1:0] sel;

  logic [2:0] rdy, hv, done, err;
  logic [3:0] node0, node1;
  logic [4:0] node2;
  logic [4:0] port0, port1, port2;
  logic [3:0] cnt0, cnt1, cnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  xy_route_stepper #(.MESH_X(4), .MESH_Y(4), .XW(2), .YW(2), .YX_FIRST(0), .HCW(4)) u_xy (
    .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(rdy[0]),
    .in_src(src[3:0]), .in_dest(dst[3:0]), .hop_valid(hv[0]), .hop_ready(hop_ready),
    .hop_node(node0), .hop_port(port0), .hop_count(cnt0),
    .route_done(done[0]), .route_err(err[0]));

  xy_route_stepper #(.MESH_X(4), .MESH_Y(4), .XW(2), .YW(2), .YX_FIRST(1), .HCW(4)) u_yx (
    .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(rdy[1]),
    .in_src(src[3:0]), .in_dest(dst[3:0]), .hop_valid(hv[1]), .hop_ready(hop_ready),
    .hop_node(node1), .hop_port(port1), .hop_count(cnt1),
    .route_done(done[1]), .route_err(err[1]));

  xy_route_stepper #(.MESH_X(3), .MESH_Y(5), .XW(2), .YW(3), .YX_FIRST(0), .HCW(4)) u_35 (
    .clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(rdy[2]),
    .in_src(src), .in_dest(dst), .hop_valid(hv[2]), .hop_ready(hop_ready),
    .hop_node(node2), .hop_port(port2), .hop_count(cnt2),
    .route_done(done[2]), .route_err(err[2]));

  // Monitor view of the selected instance
  logic       m_rdy, m_hv, m_done, m_err;
  int         m_x, m_y, m_cnt, m_port;

  always_comb begin
    m_rdy = rdy[sel]; m_hv = hv[sel]; m_done = done[sel]; m_err = err[sel];
    m_x = 0; m_y = 0; m_cnt = 0; m_port = 0;
    case (sel)
      2'd0:    begin m_x = int'(node0[3:2]); m_y = int'(node0[1:0]); m_cnt = int'(cnt0); m_port = int'(port0); end
      2'd1:    begin m_x = int'(node1[3:2]); m_y = int'(node1[1:0]); m_cnt = int'(cnt1); m_port = int'(port1); end
      default: begin m_x = int'(node2[4:3]); m_y = int'(node2[2:0]); m_cnt = int'(cnt2); m_port = int'(port2); end
    endcase
  end

  typedef struct {
    int    sel;
    int    sx, sy, dx, dy;
    bit    err;
    string ports;  // one letter per beat: E W N S L
    string nodes;  // two digits (x,y) per beat
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mkv(input int s, input int sx, input int sy, input int dx,
                               input int dy, input bit e, input string p, input string n);
    vec_t v;
    v.sel = s; v.sx = sx; v.sy = sy; v.dx = dx; v.dy = dy;
    v.err = e; v.ports = p; v.nodes = n;
    return v;
  endfunction

  function automatic logic [4:0] enc(input int s, input int x, input int y);
    logic [4:0] r;
    if (s == 2) r = {x[1:0], y[2:0]};
    else        r = {1'b0, x[1:0], y[1:0]};
    return r;
  endfunction

  function automatic int port_of(input byte c);
    case (c)
      "L":     return 1;
      "E":     return 2;
      "W":     return 4;
      "N":     return 8;
      "S":     return 16;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_beat(input vec_t v, input int k);
    chk($sformatf("v%0d beat%0d valid", v.sel, k), int'(m_hv), 1);
    chk($sformatf("v%0d beat%0d x", v.sel, k), m_x, int'(v.nodes.getc(2*k)) - 48);
    chk($sformatf("v%0d beat%0d y", v.sel, k), m_y, int'(v.nodes.getc(2*k+1)) - 48);
    chk($sformatf("v%0d beat%0d port", v.sel, k), m_port, port_of(v.ports.getc(k)));
    chk($sformatf("v%0d beat%0d count", v.sel, k), m_cnt, k);
  endtask

  // Wait (bounded) for in_ready, then present the header for one cycle
  task automatic send_hdr(input vec_t v);
    int t;
    sel = 2'(v.sel);
    hop_ready = 1'b1;
    t = 0;
    while (!m_rdy && t < 50) begin @(negedge clk); t++; end
    chk("in_ready before header", int'(m_rdy), 1);
    src = enc(v.sel, v.sx, v.sy);
    dst = enc(v.sel, v.dx, v.dy);
    vld = 3'b000;
    vld[v.sel] = 1'b1;
    @(negedge clk);
    vld = 3'b000;
  endtask

  task automatic finish_route();
    chk("route_done pulse", int'(m_done), 1);
    chk("hop_valid after done", int'(m_hv), 0);
    chk("in_ready during flag", int'(m_rdy), 0);
    @(negedge clk);
    chk("route_done clears", int'(m_done), 0);
    chk("in_ready returns", int'(m_rdy), 1);
  endtask

  task automatic run_vec(input vec_t v);
    send_hdr(v);
    if (v.err) begin
      chk("route_err pulse", int'(m_err), 1);
      chk("no hop on err", int'(m_hv), 0);
      @(negedge clk);
      chk("route_err clears", int'(m_err), 0);
      chk("no hop after err", int'(m_hv), 0);
      chk("in_ready after err", int'(m_rdy), 1);
    end else begin
      for (int k = 0; k < v.ports.len(); k++) begin
        chk_beat(v, k);
        @(negedge clk);
      end
      finish_route();
    end
  endtask

  initial begin
    vecs[0] = mkv(0, 0, 0, 2, 3, 1'b0, "EENNNL",  "001020212223");
    vecs[1] = mkv(1, 0, 0, 2, 3, 1'b0, "NNNEEL",  "000102031323");
    vecs[2] = mkv(0, 1, 1, 1, 1, 1'b0, "L",       "11");
    vecs[3] = mkv(2, 0, 0, 3, 0, 1'b1, "",        "");
    vecs[4] = mkv(2, 2, 4, 0, 0, 1'b0, "WWSSSSL", "24140403020100");
    vecs[5] = mkv(0, 3, 3, 0, 0, 1'b0, "WWWSSSL", "33231303020100");
    vecs[6] = mkv(1, 3, 0, 1, 2, 1'b0, "NNWWL",   "3031322212");
    vecs[7] = mkv(2, 0, 5, 0, 0, 1'b1, "",        "");

    rst = 1'b1; vld = 3'b000; hop_ready = 1'b1; src = '0; dst = '0; sel = 2'd0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #0;
      chk($sformatf("reset in_ready[%0d]", s), int'(m_rdy), 1);
      chk($sformatf("reset hop_valid[%0d]", s), int'(m_hv), 0);
      chk($sformatf("reset node[%0d]", s), m_x * 8 + m_y, 0);
      chk($sformatf("reset port[%0d]", s), m_port, 0);
      chk($sformatf("reset count[%0d]", s), m_cnt, 0);
      chk($sformatf("reset done/err[%0d]", s), int'(m_done) + int'(m_err), 0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Backpressure at beat 2 with a stray header offered meanwhile
    send_hdr(vecs[0]);
    for (int k = 0; k < vecs[0].ports.len(); k++) begin
      chk_beat(vecs[0], k);
      if (k == 2) begin
        hop_ready = 1'b0;
        src = enc(0, 3, 3);
        dst = enc(0, 0, 0);
        vld[0] = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk_beat(vecs[0], k);
        end
        vld = 3'b000;
        hop_ready = 1'b1;
      end
      @(negedge clk);
    end
    finish_route();
    @(negedge clk);
    chk("stray header not latched", int'(m_hv), 0);

    // Reset asserted while the third beat is on the bus
    send_hdr(vecs[5]);
    for (int k = 0; k < 3; k++) begin
      chk_beat(vecs[5], k);
      if (k < 2) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst mid hop_valid", int'(m_hv), 0);
    chk("rst mid in_ready", int'(m_rdy), 1);
    chk("rst mid done", int'(m_done), 0);
    chk("rst mid count", m_cnt, 0);
    chk("rst mid port", m_port, 0);
    @(negedge clk);
    chk("rst mid no late done", int'(m_done), 0);
    run_vec(vecs[2]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
